reg_bank: RTL and testbench

//  Parametrised general-purpose register bank; next generation of the single A/B registers.

---
 rtl/reg_bank_if.sv | 26 ++
 rtl/reg_bank.sv | 96 +++++++++
 tb/tb_reg_bank.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// Control and status bundle of the register bank: op decode inputs from the sequencer,
// flags back to its branch logic. The shared data bus stays a plain inout port on the bank.
interface reg_bank_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]       op;
    logic [AW-1:0]    wsel;
    logic [AW-1:0]    rsel;
    logic             oe;
    logic [WIDTH-1:0] imm;
    logic             zero;
    logic             carry;

    modport master (
        output op, wsel, rsel, oe, imm,
        input  zero, carry
    );

    modport slave (
        input  op, wsel, rsel, oe, imm,
        output zero, carry
    );
endinterface

// File: rtl/reg_bank.sv
// DEPTH x WIDTH general-purpose register bank with one op per cycle on register[wsel],
// registered zero/carry flags, and a combinational tristate read onto the shared bus.
module reg_bank #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             grst,
    input  logic             lrst,
    inout  wire  [WIDTH-1:0] bus,
    reg_bank_if.slave        ctl
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDI = 3'd1,
        OP_LDB = 3'd2,
        OP_INC = 3'd3,
        OP_DEC = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_CLR = 3'd7
    } op_e;

    logic [WIDTH-1:0] regs [DEPTH];
    logic             zero_q;
    logic             carry_q;

    logic             w_ok;
    logic             r_ok;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] nxt;
    logic             nxt_carry;
    logic             wr;
    op_e              op;

    // Selects beyond DEPTH (non power-of-two banks) address nothing.
    assign w_ok = ({1'b0, ctl.wsel} < DEPTH_W);
    assign r_ok = ({1'b0, ctl.rsel} < DEPTH_W);
    assign op   = op_e'(ctl.op);

    assign cur = w_ok ? regs[ctl.wsel] : '0;
    assign rd  = r_ok ? regs[ctl.rsel] : '0;

    // Reads see the pre-edge contents; a same-cycle write is not bypassed.
    assign bus = ctl.oe ? rd : 'z;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        nxt       = cur;
        nxt_carry = 1'b0;
        wr        = 1'b1;
        case (op)
            OP_NOP: wr = 1'b0;
            OP_LDI: nxt = ctl.imm;
            OP_LDB: nxt = bus;
            OP_INC: {nxt_carry, nxt} = {1'b0, cur} + (WIDTH + 1)'(1);
            OP_DEC: begin
                nxt       = cur - WIDTH'(1);
                nxt_carry = (cur == '0);
            end
            OP_SHL: {nxt_carry, nxt} = {cur, 1'b0};
            OP_SHR: {nxt, nxt_carry} = {1'b0, cur};
            OP_CLR: nxt = '0;
            default: wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
        if (grst) begin
            // NOTE: the register array is reset explicitly so no X can reach bus or flags afterwards.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
        end else if (w_ok) begin
            if (lrst) begin
                regs[ctl.wsel] <= '0;
                zero_q         <= 1'b1;
                carry_q        <= 1'b0;
            end else if (wr) begin
                regs[ctl.wsel] <= nxt;
                zero_q         <= (nxt == '0);
                carry_q        <= nxt_carry;
            end
        end
    end

    assign ctl.zero  = zero_q;
    assign ctl.carry = carry_q;
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an arithmetic model of the bank.
module tb_reg_bank;
    localparam int W  = 4;
    localparam int D  = 5;
    localparam int AW = $clog2(D);
    localparam int M  = 1 << W;

    logic         clk = 1'b0;
    logic         grst;
    logic         lrst;
    wire  [W-1:0] bus;
    logic         ext_en;
    logic [W-1:0] ext_val;

    assign bus = ext_en ? ext_val : 'z;

    reg_bank_if #(.WIDTH(W), .DEPTH(D)) ifc ();

    reg_bank #(.WIDTH(W), .DEPTH(D)) dut (
        .clk  (clk),
        .grst (grst),
        .lrst (lrst),
        .bus  (bus),
        .ctl  (ifc.slave)
    );

    always #5 clk = ~clk;

    int mreg [D];
    int mzero;
    int mcarry;
    bit chk_en;
    int n_vec;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_bus();
        if (ifc.oe)
            return (int'(ifc.rsel) < D) ? mreg[ifc.rsel] : 0;
        return int'(ext_val);
    endfunction

    // Reference model: register contents as integers, updated from the op rules.
    always @(posedge clk) begin
        int old, nv, c;
        if (grst) begin
            foreach (mreg[i]) mreg[i] = 0;
            mzero  = 1;
            mcarry = 0;
        end else if (int'(ifc.wsel) < D) begin
            if (lrst) begin
                mreg[ifc.wsel] = 0;
                mzero  = 1;
                mcarry = 0;
            end else if (ifc.op != 3'd0) begin
                old = mreg[ifc.wsel];
                nv  = old;
                c   = 0;
                case (ifc.op)
                    3'd1: nv = int'(ifc.imm);
                    3'd2: nv = exp_bus();
                    3'd3: begin nv = (old + 1) % M;     c = (old == M - 1); end
                    3'd4: begin nv = (old - 1 + M) % M; c = (old == 0);     end
                    3'd5: begin nv = (old * 2) % M;     c = (old >= M / 2); end
                    3'd6: begin nv = old / 2;           c = old % 2;        end
                    default: nv = 0;
                endcase
                mreg[ifc.wsel] = nv;
                mzero  = (nv == 0);
                mcarry = c;
            end
        end
    end

    // Per-cycle comparison of flags and bus against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("zero",  32'(ifc.zero),  32'(mzero));
            check("carry", 32'(ifc.carry), 32'(mcarry));
            if (ifc.oe || ext_en)
                check("bus", 32'(bus), 32'(exp_bus()));
        end
    end

    task automatic set(input logic [2:0] op, input int wsel, input int rsel,
                       input logic oe, input logic [W-1:0] imm);
        ifc.op   = op;
        ifc.wsel = AW'(wsel);
        ifc.rsel = AW'(rsel);
        ifc.oe   = oe;
        ifc.imm  = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_vec = 0; n_fail = 0; chk_en = 0;
        grst = 1'b0; lrst = 1'b0; ext_en = 1'b0; ext_val = '0;
        set(3'd0, 0, 0, 1'b0, '0);
        tick();

        // 1: reset state of every register and both flags
        grst = 1'b1;
        tick();
        grst = 1'b0;
        chk_en = 1;
        for (int r = 0; r < D; r++) begin
            set(3'd0, 0, r, 1'b1, '0);
            @(negedge clk);
            check("rst_bus", 32'(bus), 32'h0);
            check("rst_zero", 32'(ifc.zero), 32'h1);
            check("rst_carry", 32'(ifc.carry), 32'h0);
            tick();
        end

        // 2: INC wrap and DEC borrow
        set(3'd1, 1, 1, 1'b0, 4'hF); tick();
        set(3'd3, 1, 1, 1'b1, '0);   tick();
        set(3'd0, 0, 1, 1'b1, '0);
        @(negedge clk);
        check("inc_wrap_bus", 32'(bus), 32'h0);
        check("inc_wrap_carry", 32'(ifc.carry), 32'h1);
        check("inc_wrap_zero", 32'(ifc.zero), 32'h1);
        tick();
        set(3'd4, 1, 1, 1'b1, '0);   tick();
        set(3'd0, 0, 1, 1'b1, '0);
        @(negedge clk);
        check("dec_borrow_bus", 32'(bus), 32'hF);
        check("dec_borrow_carry", 32'(ifc.carry), 32'h1);
        check("dec_borrow_zero", 32'(ifc.zero), 32'h0);
        tick();

        // 3: LDB from an external driver, then SHL and SHR
        ext_en = 1'b1; ext_val = 4'hA;
        set(3'd2, 2, 0, 1'b0, '0); tick();
        ext_en = 1'b0;
        set(3'd5, 2, 2, 1'b1, '0);
        @(negedge clk);
        check("ldb_bus", 32'(bus), 32'hA);
        tick();
        set(3'd6, 2, 2, 1'b1, '0);
        @(negedge clk);
        check("shl_bus", 32'(bus), 32'h4);
        check("shl_carry", 32'(ifc.carry), 32'h1);
        tick();
        set(3'd0, 0, 2, 1'b1, '0);
        @(negedge clk);
        check("shr_bus", 32'(bus), 32'h2);
        check("shr_carry", 32'(ifc.carry), 32'h0);
        tick();

        // 4: lrst beats op and touches only the selected register
        set(3'd1, 0, 0, 1'b0, 4'h5); tick();
        set(3'd1, 3, 0, 1'b0, 4'h9); tick();
        lrst = 1'b1;
        set(3'd3, 3, 0, 1'b0, '0);   tick();
        lrst = 1'b0;
        set(3'd0, 0, 3, 1'b1, '0);
        @(negedge clk);
        check("lrst_r3", 32'(bus), 32'h0);
        check("lrst_zero", 32'(ifc.zero), 32'h1);
        #1 ifc.rsel = AW'(0);
        #1 check("lrst_r0_kept", 32'(bus), 32'h5);
        tick();

        // 5: same-register read/write shows old value; out-of-range wsel is a no-op
        set(3'd1, 1, 0, 1'b0, 4'h6); tick();
        set(3'd3, 1, 1, 1'b1, '0);
        @(negedge clk);
        check("rw_old_bus", 32'(bus), 32'h6);
        tick();
        set(3'd1, D, 1, 1'b1, 4'h3);
        @(negedge clk);
        check("rw_new_bus", 32'(bus), 32'h7);
        tick();
        set(3'd0, 0, 1, 1'b1, '0);
        @(negedge clk);
        check("oor_wsel_bus", 32'(bus), 32'h7);
        check("oor_wsel_zero", 32'(ifc.zero), 32'h0);
        #1 ifc.rsel = AW'(D + 1);
        #1 check("oor_rsel_bus", 32'(bus), 32'h0);
        tick();

        // 6: grst wins over a concurrent LDI; bus released while oe=0
        ext_en = 1'b1; ext_val = 4'h5;
        grst = 1'b1;
        set(3'd1, 2, 0, 1'b0, 4'hC); tick();
        grst = 1'b0;
        set(3'd0, 0, 0, 1'b0, '0);
        @(negedge clk);
        check("grst_bus_released", 32'(bus), 32'h5);
        check("grst_zero", 32'(ifc.zero), 32'h1);
        check("grst_carry", 32'(ifc.carry), 32'h0);
        tick();
        ext_en = 1'b0;
        for (int r = 0; r < D; r++) begin
            set(3'd0, 0, r, 1'b1, '0);
            @(negedge clk);
            check("grst_reg", 32'(bus), 32'h0);
            tick();
        end

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] op;
            logic       oe;
            op = 3'($urandom_range(0, 7));
            oe = 1'($urandom_range(0, 1));
            set(op, $urandom_range(0, (1 << AW) - 1), $urandom_range(0, (1 << AW) - 1),
                oe, W'($urandom_range(0, M - 1)));
            ext_en  = !oe && (op == 3'd2 || $urandom_range(0, 1) == 1);
            ext_val = W'($urandom_range(0, M - 1));
            grst    = ($urandom_range(0, 63) == 0);
            lrst    = ($urandom_range(0, 15) == 0);
            tick();
        end
        grst = 1'b0; lrst = 1'b0; ext_en = 1'b0;
        set(3'd0, 0, 0, 1'b0, '0);
        @(negedge clk);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
